// File: rtl/pwm_capture_if.sv
// pwm_capture_if: PWM line, capture enable and measurement results for pwm_capture.
// The master drives pwm_in/enable and consumes results; the slave is the capture block.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic             enable;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             ovf_o;

  modport master (
    output pwm_in, enable,
    input  period_o, high_o, valid_o, ovf_o
  );

  modport slave (
    input  pwm_in, enable,
    output period_o, high_o, valid_o, ovf_o
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period (rise-to-rise) and high time (rise-to-fall) of an asynchronous
// PWM line in clk cycles. Define PWM_CAPTURE_FILTER_EN to add a 3-sample glitch filter.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  pwm_capture_if.slave cap
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             s1, s2;
  logic             lvl_q, lvl_d;
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] per_cnt, per_d;
  logic [CNT_W-1:0] hi_lat, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

`ifdef PWM_CAPTURE_FILTER_EN
  logic h1, h2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h1 <= 1'b0;
      h2 <= 1'b0;
    end else begin
      h1 <= s2;
      h2 <= h1;
    end
  end

  // Level only moves once three consecutive synchronized samples agree.
  always_comb begin
    lvl_d = lvl_q;
    if (s2 && h1 && h2)
      lvl_d = 1'b1;
    else if (!s2 && !h1 && !h2)
      lvl_d = 1'b0;
  end
`else
  always_comb lvl_d = s2;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= cap.pwm_in;
      s2     <= s1;
      lvl_q  <= lvl_d;
      rise_q <= lvl_d & ~lvl_q;
      fall_q <= ~lvl_d & lvl_q;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    per_d    = per_cnt;
    hi_d     = hi_lat;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    ovf_d    = 1'b0;
    if (!cap.enable) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          per_d   = '0;
          hi_d    = '0;
        end
        WAIT_RISE: begin
          if (rise_q) begin
            state_d = MEASURE;
            per_d   = '0;
            hi_d    = '0;
          end
        end
        MEASURE: begin
          // A rise on the saturated count would need period 2^CNT_W: also an overflow.
          if (per_cnt == CNT_MAX) begin
            ovf_d   = 1'b1;
            state_d = WAIT_RISE;
            per_d   = '0;
            hi_d    = '0;
          end else if (rise_q) begin
            valid_d  = 1'b1;
            period_d = per_cnt + 1'b1;
            high_d   = hi_lat;
            per_d    = '0;
            hi_d     = '0;
          end else begin
            per_d = per_cnt + 1'b1;
            if (fall_q)
              hi_d = per_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      per_cnt  <= '0;
      hi_lat   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_cnt  <= per_d;
      hi_lat   <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cap.period_o = period_q;
  assign cap.high_o   = high_q;
  assign cap.valid_o  = valid_q;
  assign cap.ovf_o    = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives one PWM line into a 16-bit and a 4-bit pwm_capture and compares
// every output each cycle against an event-level model of the measurement rules.
module tb_pwm_capture;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pwm = 1'b0;
  logic enable = 1'b0;

  int checks = 0;
  int failures = 0;

  pwm_capture_if #(.CNT_W(16)) cap16 ();
  pwm_capture_if #(.CNT_W(4))  cap4 ();

  assign cap16.pwm_in = pwm;
  assign cap16.enable = enable;
  assign cap4.pwm_in  = pwm;
  assign cap4.enable  = enable;

  pwm_capture #(.CNT_W(16)) u_dut16 (.clk(clk), .resetn(resetn), .cap(cap16));
  pwm_capture #(.CNT_W(4))  u_dut4  (.clk(clk), .resetn(resetn), .cap(cap4));

  always #5 clk = ~clk;

  // Model state: index 0 models the 16-bit instance, index 1 the 4-bit one.
  longint maxv[2] = '{65535, 15};
  longint e;
  bit     r0, r1, flv;
  bit [1:0] ev_q[$];
  bit     run_m[2], ref_m[2];
  longint start_m[2], fall_m[2];
  longint exp_per[2], exp_hi[2];
  bit     exp_val[2], exp_ovf[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    r0 = 0; r1 = 0; flv = 0;
    ev_q.delete();
    for (int k = 0; k < 3; k++) ev_q.push_back(2'b00);
    for (int i = 0; i < 2; i++) begin
      run_m[i] = 0; ref_m[i] = 0; start_m[i] = 0; fall_m[i] = 0;
      exp_per[i] = 0; exp_hi[i] = 0; exp_val[i] = 0; exp_ovf[i] = 0;
    end
  endfunction

  // Measurement rules applied to a detected edge that reaches the capture logic at edge e.
  function automatic void rules(input int i, input bit en, input bit rise, input bit fall);
    exp_val[i] = 0;
    exp_ovf[i] = 0;
    if (!en) begin
      run_m[i] = 0;
      ref_m[i] = 0;
    end else if (!run_m[i]) begin
      run_m[i] = 1;
    end else if (!ref_m[i]) begin
      if (rise) begin
        ref_m[i] = 1; start_m[i] = e; fall_m[i] = e;
      end
    end else if (e - start_m[i] - 1 == maxv[i]) begin
      exp_ovf[i] = 1;
      ref_m[i] = 0;
    end else if (rise) begin
      exp_val[i] = 1;
      exp_per[i] = e - start_m[i];
      exp_hi[i]  = fall_m[i] - start_m[i];
      start_m[i] = e; fall_m[i] = e;
    end else if (fall) begin
      fall_m[i] = e;
    end
  endfunction

  task automatic compare_all();
    check("period16", cap16.period_o, 32'(exp_per[0]));
    check("high16",   cap16.high_o,   32'(exp_hi[0]));
    check("valid16",  cap16.valid_o,  32'(exp_val[0]));
    check("ovf16",    cap16.ovf_o,    32'(exp_ovf[0]));
    check("period4",  cap4.period_o,  32'(exp_per[1]));
    check("high4",    cap4.high_o,    32'(exp_hi[1]));
    check("valid4",   cap4.valid_o,   32'(exp_val[1]));
    check("ovf4",     cap4.ovf_o,     32'(exp_ovf[1]));
    check("excl4",    cap4.valid_o & cap4.ovf_o, 32'd0);
  endtask

  // One clock: present pwm level p, advance the model, sample outputs 1 time unit after the edge.
  task automatic step(input bit p);
    bit nf;
    bit [1:0] ev, ev_now;
    pwm = p;
    @(posedge clk);
    e++;
    if (!resetn) begin
      model_reset();
    end else begin
`ifdef PWM_CAPTURE_FILTER_EN
      nf = (p && r0 && r1) ? 1'b1 : (!p && !r0 && !r1) ? 1'b0 : flv;
`else
      nf = p;
`endif
      r1 = r0;
      r0 = p;
      ev = {nf & ~flv, ~nf & flv};
      flv = nf;
      ev_q.push_back(ev);
      ev_now = ev_q.pop_front();
      for (int i = 0; i < 2; i++) rules(i, enable, ev_now[1], ev_now[0]);
    end
    #1;
    compare_all();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hi; j++) step(1'b1);
      for (int j = 0; j < lo; j++) step(1'b0);
    end
  endtask

  initial begin
    e = 0;
    model_reset();

    // Reset held with the line toggling, then released with capture disabled.
    wave(2, 2, 3);
    resetn = 1'b1;
    wave(3, 3, 6);

    // 10/3 for four periods, then a change to 20/15.
    enable = 1'b1;
    wave(3, 7, 4);
    wave(15, 5, 3);

    // Line stuck low: the 4-bit instance saturates, then 8/2 restarts cleanly.
    for (int j = 0; j < 70; j++) step(1'b0);
    wave(2, 6, 4);

    // Period 15 fits the 4-bit counter; period 16 coincides with saturation.
    wave(2, 13, 3);
    wave(2, 14, 3);

    // Enable dropped mid-period with the line still toggling, then re-raised.
    wave(3, 7, 3);
    step(1'b1);
    enable = 1'b0;
    step(1'b1);
    wave(3, 7, 3);
    enable = 1'b1;
    wave(3, 7, 3);

    // 12/6 with a one-cycle low glitch inside the high phase.
    for (int k = 0; k < 4; k++) begin
      step(1'b1); step(1'b1); step(1'b1); step(1'b0); step(1'b1); step(1'b1);
      for (int j = 0; j < 6; j++) step(1'b0);
    end

    // Randomized periods with occasional enable drops.
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(19, 0) == 0) begin
        enable = 1'b0;
        wave(3, 3, 1);
        enable = 1'b1;
      end
      wave(int'($urandom_range(18, 3)), int'($urandom_range(18, 3)), 1);
    end

    // Asynchronous reset in the middle of a high phase.
    wave(4, 6, 2);
    step(1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_period16", cap16.period_o, 32'd0);
    check("rst_high16",   cap16.high_o,   32'd0);
    check("rst_valid16",  cap16.valid_o,  32'd0);
    check("rst_period4",  cap4.period_o,  32'd0);
    wave(2, 2, 2);
    resetn = 1'b1;
    wave(5, 6, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
